// File: rtl/pe_pkg.sv
// Shared types and constants for the CGRA PE slice: opcodes, crossbar sources, config field map.
package pe_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_MUL   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_XOR   = 4'd5,
      OP_SHL   = 4'd6,
      OP_SHR   = 4'd7,
      OP_SRA   = 4'd8,
      OP_EQ    = 4'd9,
      OP_LT    = 4'd10,
      OP_LTU   = 4'd11,
      OP_PASSA = 4'd12,
      OP_PASSB = 4'd13,
      OP_NOT   = 4'd14,
      OP_ZERO  = 4'd15
   } op_e;

   localparam logic [1:0] SRC_IN0 = 2'd0;
   localparam logic [1:0] SRC_IN1 = 2'd1;
   localparam logic [1:0] SRC_IN2 = 2'd2;
   localparam logic [1:0] SRC_ALU = 2'd3;

   localparam int unsigned CFG_W     = 13;
   localparam int unsigned OP_LSB    = 0;
   localparam int unsigned OP_W      = 4;
   localparam int unsigned OSEL_BIT  = 4;
   localparam int unsigned XSEL_W    = 2;
   localparam int unsigned XSEL0_LSB = 5;
   localparam int unsigned XB_N      = 4;

   // Bit offset of the select field for crossbar output k.
   function automatic int unsigned xsel_lsb(input int unsigned k);
      return XSEL0_LSB + k * XSEL_W;
   endfunction

endpackage

// File: rtl/pe_alu.sv
// Combinational two-operand ALU for the PE slice.
// Opcode 2 multiplies only when PE_MUL_EN is defined; otherwise it yields zero.
module pe_alu
   import pe_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  op_e          op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);

   localparam int unsigned SHW = $clog2(W);

   logic [SHW-1:0] sh;
   assign sh = b_i[SHW-1:0];

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD:   y_o = a_i + b_i;
         OP_SUB:   y_o = a_i - b_i;
`ifdef PE_MUL_EN
         OP_MUL:   y_o = a_i * b_i;
`else
         OP_MUL:   y_o = '0;
`endif
         OP_AND:   y_o = a_i & b_i;
         OP_OR:    y_o = a_i | b_i;
         OP_XOR:   y_o = a_i ^ b_i;
         OP_SHL:   y_o = a_i << sh;
         OP_SHR:   y_o = a_i >> sh;
         OP_SRA:   y_o = W'($signed(a_i) >>> sh);
         OP_EQ:    y_o = W'(a_i == b_i);
         OP_LT:    y_o = W'($signed(a_i) < $signed(b_i));
         OP_LTU:   y_o = W'(a_i < b_i);
         OP_PASSA: y_o = a_i;
         OP_PASSB: y_o = b_i;
         OP_NOT:   y_o = ~a_i;
         default:  y_o = '0;
      endcase
   end

endmodule

// File: rtl/pe_alu_xbar.sv
// CGRA PE slice: 4x4 crossbar into a registered ALU, output selector, 13-bit serial config chain.
// Define PE_MUL_EN to include the multiplier for opcode 2.
module pe_alu_xbar
   import pe_pkg::*;
#(
   parameter int unsigned size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            config_en,
   input  logic            config_in,
   output logic            config_out,
   input  logic [size-1:0] in0,
   input  logic [size-1:0] in1,
   input  logic [size-1:0] in2,
   output logic [size-1:0] out0,
   output logic [size-1:0] xout2,
   output logic [size-1:0] xout3
);

   logic [CFG_W-1:0] cfg_q;
   logic [size-1:0]  alu_q;
   logic [size-1:0]  alu_d;
   logic [size-1:0]  src [XB_N];
   logic [size-1:0]  xb  [XB_N];
   op_e              op;

   // Config chain and ALU result register; fields act directly, no shadow copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q <= '0;
         alu_q <= '0;
      end else begin
         if (config_en) cfg_q <= {cfg_q[CFG_W-2:0], config_in};
         alu_q <= alu_d;
      end
   end

   assign src[SRC_IN0] = in0;
   assign src[SRC_IN1] = in1;
   assign src[SRC_IN2] = in2;
   assign src[SRC_ALU] = alu_q;

   for (genvar k = 0; k < XB_N; k++) begin : g_xbar
      assign xb[k] = src[cfg_q[xsel_lsb(k) +: XSEL_W]];
   end

   assign op = op_e'(cfg_q[OP_LSB +: OP_W]);

   pe_alu #(.W(size)) u_alu (
      .op_i (op),
      .a_i  (xb[0]),
      .b_i  (xb[1]),
      .y_o  (alu_d)
   );

   assign config_out = cfg_q[CFG_W-1];
   assign out0       = cfg_q[OSEL_BIT] ? in2 : alu_q;
   assign xout2      = xb[2];
   assign xout3      = xb[3];

endmodule

// File: tb/tb_pe_alu_xbar.sv
// Randomised self-checking bench for pe_alu_xbar against a behavioural PE model.
module tb_pe_alu_xbar;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        config_en = 1'b0;
   logic        config_in = 1'b0;
   logic        config_out;
   logic [31:0] in0 = '0, in1 = '0, in2 = '0;
   logic [31:0] out0, xout2, xout3;

   int errors = 0;
   int checks = 0;

   bit [12:0] m_c;
   bit [31:0] m_alu;
   bit        m_valid = 1'b0;

   pe_alu_xbar #(.size(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .config_en  (config_en),
      .config_in  (config_in),
      .config_out (config_out),
      .in0        (in0),
      .in1        (in1),
      .in2        (in2),
      .out0       (out0),
      .xout2      (xout2),
      .xout3      (xout3)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [31:0] ref_alu(input int op, input bit [31:0] a, input bit [31:0] b);
      int unsigned sh = b % 32;
      int          sa = a;
      case (op)
         0:  return a + b;
         1:  return a - b;
`ifdef PE_MUL_EN
         2:  return a * b;
`else
         2:  return 32'd0;
`endif
         3:  return a & b;
         4:  return a | b;
         5:  return a ^ b;
         6:  return a << sh;
         7:  return a >> sh;
         8:  return sa >>> sh;
         9:  return (a == b) ? 32'd1 : 32'd0;
         10: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         11: return (a < b) ? 32'd1 : 32'd0;
         12: return a;
         13: return b;
         14: return ~a;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit [31:0] pick(input bit [1:0] s);
      bit [31:0] srcs [4];
      srcs = '{in0, in1, in2, m_alu};
      return srcs[s];
   endfunction

   // Behavioural model: config shift register and ALU result, advanced on each clock.
   always @(posedge clk) begin
      if (reset) begin
         m_c     <= '0;
         m_alu   <= '0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_alu <= ref_alu(int'(m_c[3:0]), pick(m_c[6:5]), pick(m_c[8:7]));
         if (config_en) m_c <= 13'((m_c << 1) | 13'(config_in));
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         check("out0", out0, m_c[4] ? in2 : m_alu);
         check("xout2", xout2, pick(m_c[10:9]));
         check("xout3", xout3, pick(m_c[12:11]));
         check("config_out", {31'd0, config_out}, {31'd0, m_c[12]});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [12:0] v);
      config_en = 1'b1;
      for (int i = 12; i >= 0; i--) begin
         config_in = v[i];
         tick();
      end
      config_en = 1'b0;
      config_in = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 40));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [26:1] pat;

      // Reset state and default ADD with a=b=in0
      do_reset();
      check("rst_out0", out0, 32'd0);
      check("rst_cfg_out", {31'd0, config_out}, 32'd0);
      load_cfg(13'h000);
      check("zero_load_out0", out0, 32'd0);
      in0 = 32'd5;
      tick();
      check("add_5_5", out0, 32'd10);

      // SUB with a=in0, b=in1
      load_cfg(13'h081);
      in0 = 32'd100; in1 = 32'd42;
      tick();
      check("sub_100_42", out0, 32'd58);
      in0 = 32'd0; in1 = 32'd1;
      tick();
      check("sub_0_1", out0, 32'hFFFF_FFFF);

      // Feedback accumulate: a=alu_q, b=in0
      in0 = '0; in1 = '0; in2 = '0;
      do_reset();
      load_cfg(13'h060);
      check("acc_start", out0, 32'd0);
      in0 = 32'd1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("acc", out0, 32'(i));
      end

      // Shifts and compares, a=in0, b=in1
      load_cfg(13'h088);
      in0 = 32'h8000_0000; in1 = 32'd4;
      tick();
      check("sra", out0, 32'hF800_0000);
      load_cfg(13'h086);
      in0 = 32'h0000_0003; in1 = 32'd33;
      tick();
      check("shl_wrap", out0, 32'd6);
      load_cfg(13'h08A);
      in0 = 32'hFFFF_FFFF; in1 = 32'd1;
      tick();
      check("lt_signed", out0, 32'd1);
      load_cfg(13'h08B);
      tick();
      check("ltu", out0, 32'd0);

      // Bypass and crossbar routing
      load_cfg(13'h010);
      in2 = 32'hDEAD_BEEF;
      tick();
      check("bypass", out0, 32'hDEAD_BEEF);
      load_cfg(13'h1200);
      in1 = 32'h0000_1111; in2 = 32'h0000_2222;
      tick();
      check("xout2_in1", xout2, 32'h0000_1111);
      check("xout3_in2", xout3, 32'h0000_2222);

      // Chain pass-through of 26 bits, watching bits 14..26 emerge
      pat = 26'($urandom);
      config_en = 1'b1;
      for (int k = 1; k <= 38; k++) begin
         config_in = (k <= 26) ? pat[k] : 1'b0;
         tick();
         if (k >= 26) check("chain", {31'd0, config_out}, {31'd0, pat[k-12]});
      end

      // Reset mid-shift wins over config_en and discards the partial load
      for (int k = 0; k < 6; k++) begin
         config_in = 1'b1;
         tick();
      end
      reset = 1'b1;
      tick();
      check("midrst_cfg_out", {31'd0, config_out}, 32'd0);
      check("midrst_out0", out0, 32'd0);
      reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
      in0 = 32'd7;
      tick();
      check("after_midrst_add", out0, 32'd14);

      // Multiply (or zero when the multiplier is absent)
      load_cfg(13'h082);
      in0 = 32'h0001_0000; in1 = 32'h0001_0000;
      tick();
      check("mul_wrap", out0, 32'd0);
      in0 = 32'd3; in1 = 32'd5;
      tick();
`ifdef PE_MUL_EN
      check("mul_3_5", out0, 32'd15);
`else
      check("mul_3_5", out0, 32'd0);
`endif

      // Randomised configs, data, occasional mid-run shifting and resets
      for (int r = 0; r < 40; r++) begin
         load_cfg(13'($urandom));
         for (int c = 0; c < 30; c++) begin
            in0 = rnd_val(); in1 = rnd_val(); in2 = rnd_val();
            config_en = ($urandom_range(0, 15) == 0);
            config_in = 1'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            tick();
         end
         reset = 1'b0;
         config_en = 1'b0;
      end

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_alu_xbar.md
Name: pe_alu_xbar

Overview:
- CGRA processing-element slice: a 4x4 input crossbar feeds a registered two-operand ALU, and a 2:1 output selector drives the PE output.
- All routing and the opcode come from a 13-bit serial configuration chain, shifted on the data clock.
- Instantiated per PE tile; the chain daisy-chains through neighbouring tiles.

Parameters:
- size, 32, data width of every data port and internal datapath (min 8).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- config_en  in  1  shift enable for the config chain.
- config_in  in  1  serial config bit in.
- config_out  out  1  serial config bit out (to the next tile).
- in0  in  size  external operand 0.
- in1  in  size  external operand 1.
- in2  in  size  external operand 2 (bypass/memory return).
- out0  out  size  PE result.
- xout2  out  size  crossbar output 2 (memory address).
- xout3  out  size  crossbar output 3 (memory data).

Behaviour:
- Config register C[12:0]:
  - On posedge clk with config_en=1: C <= {C[11:0], config_in}.
  - config_out = C[12] (registered).
  - Load by presenting 13 bits MSB-first over 13 enabled cycles.
- Field map:
  - op = C[3:0]
  - osel = C[4]
  - xsel0 = C[6:5], xsel1 = C[8:7], xsel2 = C[10:9], xsel3 = C[12:11]
- No shadow register: fields take effect the cycle after they land, including mid-shift.
- Crossbar (combinational): each output k = source selected by xselk.
  - 0 = in0, 1 = in1, 2 = in2, 3 = alu_q (registered ALU result feedback; no combinational loop).
  - a = xbar out0, b = xbar out1.
  - xout2 and xout3 are xbar out2 and out3.
- ALU: alu_q <= f(op, a, b) each clock; one-cycle latency; all results truncated to size bits. Opcodes:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 MUL low size bits of a*b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL a<<b[4:0]
  - 7 SHR logical
  - 8 SRA arithmetic
  - 9 EQ (1 if a==b else 0)
  - 10 LT signed
  - 11 LTU
  - 12 PASSA a
  - 13 PASSB b
  - 14 NOT ~a
  - 15 ZERO 0
- Shift amount uses b[$clog2(size)-1:0]; for size=32 this is b[4:0], so amounts 32 and above wrap (b=33 shifts by 1).
- Overflow wraps silently; no flags.
- out0 = osel ? in2 : alu_q (combinational mux of a registered value and a port).
- Reset (synchronous, priority over config_en):
  - C <= 0, alu_q <= 0.
  - After reset: op=ADD, all xsel=0 (a=b=in0), osel=0, out0=0, config_out=0.
- Reset asserted mid-shift discards the partial load.
- config_en held with reset low and stable data: datapath keeps computing with the changing fields; the bench must not rely on results during loading.

Optional Feature:
- PE_MUL_EN defined: opcode 2 computes the low size bits of a*b.
- Not defined: no multiplier is synthesised and opcode 2 yields 0. All other opcodes are unaffected.

Decomposition:
- Shared package pe_pkg:
  - opcode enum (4-bit): OP_ADD … OP_ZERO
  - crossbar source constants: SRC_IN0, SRC_IN1, SRC_IN2, SRC_ALU
  - config field offsets/widths and CFG_W=13
- Sub-module pe_alu: purely combinational op decode plus arithmetic. The top level holds the alu_q register, the crossbar, the output mux and the config chain.

Test Plan:
- Reset then 13 shifts of 0: out0=0, config_out=0. in0=5 gives out0=10 one cycle later (ADD, a=b=in0).
- Load op=1, xsel0=0, xsel1=1, osel=0: in0=100, in1=42 gives out0=58 after one clock. in0=0, in1=1 gives 0xFFFFFFFF.
- Feedback accumulate: op=0, xsel0=3, xsel1=0, in0=1 after reset gives out0 = 1, 2, 3, 4 on successive cycles.
- Shifts and compares:
  - SRA a=0x80000000, b=4 gives 0xF8000000.
  - SHL b=33 gives a<<1.
  - LT a=-1, b=1 gives 1; LTU with the same operands gives 0.
- Routing and bypass: osel=1, in2=0xDEADBEEF gives out0=0xDEADBEEF. xsel2=1, xsel3=2 gives xout2=in1, xout3=in2.
- Chain pass-through: shift in 26 bits; bits 14–26 appear on config_out exactly 13 cycles after entry. Reset at shift 7 clears C and out0=0 next cycle. With PE_MUL_EN undefined, op=2 gives 0; with it defined, 0x10000*0x10000 gives 0.
